// File: rtl/apb.sv
// rtl/apb.sv - APB3-style register slave wrapping a UART TX/RX pair with internal loopback
//
// Ports:
//   PCLK     in   1   clock, all logic on the rising edge
//   PRESETn  in   1   synchronous active-low reset
//   PADDR    in   32  register word index (0 CTRL, 1 STATS, 2 TX_DATA, 3 RX_DATA)
//   PSEL     in   1   peripheral select
//   PENABLE  in   1   access phase
//   PWRITE   in   1   1 = write, 0 = read
//   PWDATA   in   32  write data
//   PRDATA   out  32  read data (0 unless a read is selected)
//   PREADY   out  1   PSEL & PENABLE, zero wait states

module apb #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [31:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    // Register state
    logic [3:0]  ctrl_q, ctrl_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        tx_en_prev_q, tx_en_prev_d;

    // Transmitter state
    uart_state_e      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_done_q, tx_done_d;

    // Receiver state
    uart_state_e      rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_done_q, rx_done_d;
    logic             rx_error_q, rx_error_d;

    logic rx_en, rx_rst, tx_rst, tx_en;
    logic wr_en;
    logic tx_start;
    logic tx_busy, rx_busy;
    logic serial_line;
    logic unused_pwdata;

    assign rx_en  = ctrl_q[0];
    assign rx_rst = ctrl_q[1];
    assign tx_rst = ctrl_q[2];
    assign tx_en  = ctrl_q[3];

    assign wr_en   = PSEL & PENABLE & PWRITE;
    assign PREADY  = PSEL & PENABLE;
    assign tx_busy = (tx_state_q != ST_IDLE);
    assign rx_busy = (rx_state_q != ST_IDLE);

    assign unused_pwdata = ^PWDATA[31:8];

    // A frame starts only on a 0->1 transition of tx_en seen while idle;
    // an edge arriving during a frame is consumed and lost.
    assign tx_start = tx_en & ~tx_en_prev_q & (tx_state_q == ST_IDLE) & ~tx_rst;

    // Register writes
    always_comb begin
        ctrl_d       = ctrl_q;
        tx_data_d    = tx_data_q;
        tx_en_prev_d = tx_en;
        if (wr_en) begin
            case (PADDR)
                32'd0:   ctrl_d    = PWDATA[3:0];
                32'd2:   tx_data_d = PWDATA[7:0];
                default: ;
            endcase
        end
    end

    // Read mux
    always_comb begin
        PRDATA = 32'd0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                32'd0:   PRDATA = {28'd0, ctrl_q};
                32'd1:   PRDATA = {27'd0, rx_error_q, rx_done_q, rx_busy, tx_done_q, tx_busy};
                32'd2:   PRDATA = {24'd0, tx_data_q};
                32'd3:   PRDATA = {24'd0, rx_data_q};
                default: PRDATA = 32'd0;
            endcase
        end
    end

    // Serial line driven by the transmitter, looped straight into the receiver
    always_comb begin
        serial_line = 1'b1;
        case (tx_state_q)
            ST_START: serial_line = 1'b0;
            ST_DATA:  serial_line = tx_shift_q[0];
            default:  serial_line = 1'b1;
        endcase
    end

    // Transmitter next state
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_done_d  = tx_done_q;
        if (tx_rst) begin
            tx_state_d = ST_IDLE;
            tx_cnt_d   = '0;
            tx_bit_d   = 3'd0;
            tx_done_d  = 1'b0;
        end else begin
            case (tx_state_q)
                ST_IDLE: begin
                    if (tx_start) begin
                        tx_state_d = ST_START;
                        tx_cnt_d   = '0;
                        tx_shift_d = tx_data_q;
                        tx_done_d  = 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_state_d = ST_DATA;
                        tx_cnt_d   = '0;
                        tx_bit_d   = 3'd0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_d   = '0;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = ST_STOP;
                        end else begin
                            tx_bit_d = tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_d = tx_cnt_q + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_state_d = ST_IDLE;
                        tx_cnt_d   = '0;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_cnt_d = tx_cnt_q + CNT_ONE;
                    end
                end
                default: tx_state_d = ST_IDLE;
            endcase
        end
    end

    // Receiver next state
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done_d  = rx_done_q;
        rx_error_d = rx_error_q;
        rx_data_d  = rx_data_q;
        if (rx_rst) begin
            rx_state_d = ST_IDLE;
            rx_cnt_d   = '0;
            rx_bit_d   = 3'd0;
            rx_done_d  = 1'b0;
            rx_error_d = 1'b0;
            rx_data_d  = 8'd0;
        end else if (!rx_en) begin
            rx_state_d = ST_IDLE;
            rx_cnt_d   = '0;
        end else begin
            case (rx_state_q)
                ST_IDLE: begin
                    if (!serial_line) begin
                        rx_state_d = ST_START;
                        rx_cnt_d   = '0;
                    end
                end
                ST_START: begin
                    // Confirm the start bit at mid-bit; a high line here was a
                    // glitch and leaves the sticky flags untouched.
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_d = '0;
                        rx_bit_d = 3'd0;
                        if (serial_line) begin
                            rx_state_d = ST_IDLE;
                        end else begin
                            rx_state_d = ST_DATA;
                            rx_done_d  = 1'b0;
                            rx_error_d = 1'b0;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_d   = '0;
                        rx_shift_d = {serial_line, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = ST_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_state_d = ST_IDLE;
                        rx_cnt_d   = '0;
                        rx_data_d  = rx_shift_q;
                        rx_done_d  = 1'b1;
                        rx_error_d = ~serial_line;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CNT_ONE;
                    end
                end
                default: rx_state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            ctrl_q       <= 4'd0;
            tx_data_q    <= 8'd0;
            rx_data_q    <= 8'd0;
            tx_en_prev_q <= 1'b0;
            tx_state_q   <= ST_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= 3'd0;
            tx_shift_q   <= 8'd0;
            tx_done_q    <= 1'b0;
            rx_state_q   <= ST_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'd0;
            rx_done_q    <= 1'b0;
            rx_error_q   <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            tx_data_q    <= tx_data_d;
            rx_data_q    <= rx_data_d;
            tx_en_prev_q <= tx_en_prev_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_done_q    <= tx_done_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_done_q    <= rx_done_d;
            rx_error_q   <= rx_error_d;
        end
    end

endmodule

// File: tb/tb_apb.sv
// tb/tb_apb.sv - self-checking bench for the apb UART loopback slave

module tb_apb;

    localparam int CPB = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: software-visible register contents and sticky flags
    logic [3:0] m_ctrl;
    logic [7:0] m_tx_data;
    logic [7:0] m_rx_data;
    logic       m_tx_done;
    logic       m_rx_done;

    apb #(.CLKS_PER_BIT(CPB)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        if (addr == 32'd0) m_ctrl = data[3:0];
        if (addr == 32'd2) m_tx_data = data[7:0];
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic rdy_setup, output logic rdy_access);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        #1 rdy_setup = PREADY;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 rdy_access = PREADY;
        data = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic rs, ra;
        apb_read(addr, d, rs, ra);
        check(tag, d, exp);
    endtask

    function automatic logic [31:0] stats_exp(input logic tx_busy, input logic rx_busy);
        return {27'd0, 1'b0, m_rx_done, rx_busy, m_tx_done, tx_busy};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge PCLK);
    endtask

    // One loopback frame: load data, pulse tx_en with rx enabled, let it finish
    task automatic send_frame(input logic [7:0] b, input logic disturb);
        apb_write(32'd2, {24'd0, b});
        apb_write(32'd0, 32'd9);
        apb_write(32'd0, 32'd1);
        m_tx_done = 1'b0;
        if (disturb) apb_write(32'd2, {24'd0, b ^ 8'h5A});
        wait_cycles(11 * CPB);
        m_tx_done = 1'b1;
        m_rx_done = 1'b1;
        m_rx_data = b;
    endtask

    initial begin
        logic [31:0] d;
        logic rs, ra;
        logic [7:0] b, y;
        logic [31:0] a;

        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'd0; PWDATA = 32'd0;
        m_ctrl = 4'd0; m_tx_data = 8'd0; m_rx_data = 8'd0;
        m_tx_done = 1'b0; m_rx_done = 1'b0;

        wait_cycles(4);
        #1 check("pready_in_reset", {31'd0, PREADY}, 32'd0);
        check("prdata_in_reset", PRDATA, 32'd0);
        @(posedge PCLK); #1 PRESETn = 1'b1;

        // Reset values and handshake
        for (int i = 0; i < 4; i++) begin
            apb_read(i, d, rs, ra);
            check($sformatf("reset_reg%0d", i), d, 32'd0);
            check($sformatf("pready_setup%0d", i), {31'd0, rs}, 32'd0);
            check($sformatf("pready_access%0d", i), {31'd0, ra}, 32'd1);
        end

        // Reset bits alone produce no activity
        apb_write(32'd0, 32'd6);
        read_check("ctrl6", 32'd0, 32'd6);
        read_check("stats_ctrl6", 32'd1, 32'd0);
        apb_write(32'd0, 32'd0);
        read_check("ctrl0", 32'd0, 32'd0);
        read_check("stats_ctrl0", 32'd1, 32'd0);

        // First directed frame, 93
        apb_write(32'd2, 32'd93);
        read_check("txdata93", 32'd2, 32'd93);
        apb_write(32'd0, 32'd9);
        apb_write(32'd0, 32'd1);
        m_tx_done = 1'b0;
        read_check("stats_busy", 32'd1, stats_exp(1'b1, 1'b1));
        wait_cycles(11 * CPB);
        m_tx_done = 1'b1; m_rx_done = 1'b1; m_rx_data = 8'd93;
        read_check("rxdata93", 32'd3, 32'd93);
        read_check("stats_done", 32'd1, stats_exp(1'b0, 1'b0));

        // Random frames, some with a TX_DATA write while the frame is in flight
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'($urandom));
            read_check($sformatf("rand_rx%0d", i), 32'd3, {24'd0, m_rx_data});
            read_check($sformatf("rand_stats%0d", i), 32'd1, stats_exp(1'b0, 1'b0));
            read_check($sformatf("rand_txd%0d", i), 32'd2, {24'd0, m_tx_data});
            a = 32'd4 + 32'($urandom_range(0, 1000));
            apb_write(a, $urandom);
            read_check($sformatf("hi_addr%0d", i), a, 32'd0);
            read_check($sformatf("rand_ctrl%0d", i), 32'd0, {28'd0, m_ctrl});
        end

        // tx_rst mid-frame with the receiver disabled
        apb_write(32'd0, 32'd0);
        apb_write(32'd2, 32'h3C);
        apb_write(32'd0, 32'd8);
        m_tx_done = 1'b0;
        wait_cycles(3 * CPB);
        read_check("stats_txonly", 32'd1, stats_exp(1'b1, 1'b0));
        apb_write(32'd0, 32'd4);
        read_check("stats_txrst", 32'd1, stats_exp(1'b0, 1'b0));
        wait_cycles(11 * CPB);
        read_check("rx_unchanged", 32'd3, {24'd0, m_rx_data});
        read_check("stats_after_txrst", 32'd1, stats_exp(1'b0, 1'b0));

        // Held tx_en sends exactly one frame
        apb_write(32'd0, 32'd1);
        y = 8'($urandom);
        apb_write(32'd2, {24'd0, y});
        apb_write(32'd0, 32'd9);
        m_tx_done = 1'b0; m_rx_done = 1'b0;
        wait_cycles(2 * CPB);
        read_check("stats_hold_busy", 32'd1, stats_exp(1'b1, 1'b1));
        apb_write(32'd2, {24'd0, ~y});
        wait_cycles(33 * CPB);
        m_tx_done = 1'b1; m_rx_done = 1'b1; m_rx_data = y;
        read_check("hold_rx_once", 32'd3, {24'd0, y});
        read_check("hold_stats", 32'd1, stats_exp(1'b0, 1'b0));
        apb_write(32'd0, 32'd1);
        send_frame(8'hA5, 1'b0);
        read_check("second_frame", 32'd3, 32'hA5);
        read_check("second_stats", 32'd1, stats_exp(1'b0, 1'b0));

        // rx_rst clears RX_DATA and rx flags
        apb_write(32'd0, 32'd2);
        m_rx_data = 8'd0; m_rx_done = 1'b0;
        read_check("rxrst_data", 32'd3, 32'd0);
        read_check("rxrst_stats", 32'd1, stats_exp(1'b0, 1'b0));
        apb_write(32'd0, 32'd0);
        read_check("ctrl_clear", 32'd0, 32'd0);

        // PRESETn mid-frame aborts with no done flags
        apb_write(32'd0, 32'd1);
        apb_write(32'd2, 32'h81);
        apb_write(32'd0, 32'd9);
        wait_cycles(3 * CPB);
        @(posedge PCLK); #1 PRESETn = 1'b0;
        wait_cycles(2);
        #1 PRESETn = 1'b1;
        m_ctrl = 4'd0; m_tx_data = 8'd0; m_rx_data = 8'd0;
        m_tx_done = 1'b0; m_rx_done = 1'b0;
        wait_cycles(11 * CPB);
        for (int i = 0; i < 4; i++) begin
            read_check($sformatf("presetn_reg%0d", i), i, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
